disp_src_sched: RTL and testbench
=================================

Name: disp_src_sched

Overview:
- Time-multiplexing scheduler that shares the single 4-digit seven-segment display between up to N_SRC data sources, such as counters and status words.
- Sits directly in front of the display driver and drives its dat/pt inputs.
- Uses the driver's ce_1ms strobe as its time base.
- Grants sources round-robin, holds each for a fixed dwell time, and inserts a blank gap between sources so the operator sees the switch.

Parameters:
N_SRC, 4, number of requesting sources (2..8)
HOLD_MS, 1000, dwell time per grant in ce_1ms ticks (>=1)
BLANK_MS, 100, blank gap between grants in ce_1ms ticks (>=1)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous reset, active-low
ce_1ms  in  1  1-cycle strobe every 1 ms (from display driver)
req  in  N_SRC  per-source "want display" level
src_dat  in  16*N_SRC  source i digits at [16*i+15:16*i]
src_pt  in  2*N_SRC  source i decimal-point select at [2*i+1:2*i]
dat  out  16  digits to display driver
pt  out  2  point select to display driver
blank  out  1  1 = display must be dark (downstream gates act)
gnt  out  N_SRC  one-hot grant, all-zero when none
cur_src  out  SRC_W  index of granted/last-granted source; SRC_W = max(1,clog2(N_SRC))

Behaviour:
- Reset (rst_n=0 at clk edge): state=IDLE, dat=0, pt=0, blank=1, gnt=0, cur_src=N_SRC-1 (so first search starts at source 0), counters=0. Reset mid-grant aborts immediately.
- All outputs are registered. dat/pt follow the granted source's src_dat/src_pt with 1-cycle latency while in SHOW; they are 0 otherwise.
- Round-robin pick: first i with req[i]=1, searching cur_src+1, cur_src+2, ... with wrap modulo N_SRC, cur_src itself last.
- IDLE: blank=1, gnt=0. When any req=1, pick a source, load cur_src, and go to SHOW next cycle with the hold counter cleared.
- SHOW:
  - gnt=onehot(cur_src), blank=0.
  - Hold counter increments only on ce_1ms.
  - When hold reaches HOLD_MS (the cycle of the HOLD_MS-th strobe), expiry is evaluated:
    - Another source is requesting: go to GAP.
    - Only cur_src is requesting: restart hold, stay in SHOW, outputs unchanged (no blank).
    - No requests: go to IDLE.
  - req[cur_src] dropping mid-dwell: on the next edge, go to GAP if any other req is set, otherwise IDLE. The partial dwell is not resumed.
- GAP:
  - blank=1, gnt=0, dat=0, pt=0.
  - Gap counter increments on ce_1ms.
  - At BLANK_MS strobes, re-pick from the current req vector. If a source is found, go to SHOW with that source. If none, go to IDLE.
  - A gap is never cut short.
- ce_1ms coincident with a state entry cycle is not counted. Counting starts the cycle after entry, so a dwell lasts HOLD_MS or HOLD_MS+1 full strobes of wall time, never fewer.
- A req that rises and falls entirely within a GAP or SHOW of another source is lost. There is no request latching.
- Counter widths: clog2(HOLD_MS+1) and clog2(BLANK_MS+1). No wrap is possible because the counters clear on expiry.
- Invariants: gnt is zero or one-hot. gnt!=0 implies blank=0. blank=0 implies state=SHOW.

Test Plan:
- Reset with req=4'b1111 and rst_n held low for 3 cycles -> blank=1, gnt=0, dat=0. After release, SHOW starts for src 0 within 2 cycles.
- HOLD_MS=3, BLANK_MS=1, req=4'b0101, src_dat0=16'h1234, src_dat2=16'hABCD -> sequence: dat=1234 for 3 strobes, blank for 1 strobe, dat=ABCD for 3 strobes, blank, back to 1234. Source 1 is never granted.
- Single requester req=4'b0010 held for 10 strobes -> gnt=4'b0010 continuously, blank never rises, and dat tracks a src_dat1 change from 0001 to 0002 one cycle later.
- req[cur_src] drops after 1 strobe with req[3]=1 -> next cycle blank=1 and gnt=0, then src 3 is granted after the gap. The same drop with no other req -> IDLE, blank=1.
- Wrap-around: cur_src=3 at expiry, req=4'b1001 -> next grant is src 0. With only req[3] set, the hold restarts.
- Random req/ce_1ms for 100k cycles -> invariants hold, and every source whose req is held steadily is granted within N_SRC*(HOLD_MS+BLANK_MS+2) strobes.

Source files
------------

// File: rtl/disp_src_sched.sv
// Round-robin time-multiplexer sharing one 4-digit display among N_SRC sources,
// with a fixed dwell per grant and a dark gap between grants, paced by ce_1ms.
module disp_src_sched #(
  parameter int N_SRC    = 4,
  parameter int HOLD_MS  = 1000,
  parameter int BLANK_MS = 100,
  localparam int SRC_W   = (N_SRC > 2) ? $clog2(N_SRC) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ce_1ms,
  input  logic [N_SRC-1:0]     req,
  input  logic [16*N_SRC-1:0]  src_dat,
  input  logic [2*N_SRC-1:0]   src_pt,
  output logic [15:0]          dat,
  output logic [1:0]           pt,
  output logic                 blank,
  output logic [N_SRC-1:0]     gnt,
  output logic [SRC_W-1:0]     cur_src
);

  localparam int HW = $clog2(HOLD_MS + 1);
  localparam int BW = $clog2(BLANK_MS + 1);

  typedef enum logic [1:0] {IDLE, SHOW, GAP} state_t;

  state_t           state, state_nxt;
  logic [SRC_W-1:0] src_nxt;
  logic [HW-1:0]    hold_cnt;
  logic [BW-1:0]    gap_cnt;
  logic [N_SRC-1:0] cur_oh;
  logic             others;
  logic             cur_req;
  logic             hold_exp, gap_exp;
  logic             pick_vld;
  logic [SRC_W-1:0] pick_idx;

  logic [15:0]      dat_d;
  logic [1:0]       pt_d;
  logic             blank_d;
  logic [N_SRC-1:0] gnt_d;

  assign cur_oh   = N_SRC'(1) << cur_src;
  assign cur_req  = req[cur_src];
  assign others   = |(req & ~cur_oh);
  assign hold_exp = ce_1ms && (hold_cnt == HW'(HOLD_MS - 1));
  assign gap_exp  = ce_1ms && (gap_cnt == BW'(BLANK_MS - 1));

  // Descending scan so the nearest requester after cur_src wins; cur_src is tried last.
  always_comb begin
    int idx;
    idx      = 0;
    pick_vld = 1'b0;
    pick_idx = cur_src;
    for (int k = N_SRC; k >= 1; k--) begin
      idx = int'(cur_src) + k;
      if (idx >= N_SRC) idx = idx - N_SRC;
      if (req[idx]) begin
        pick_vld = 1'b1;
        pick_idx = SRC_W'(idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      cur_src <= SRC_W'(N_SRC - 1);
    end else begin
      state   <= state_nxt;
      cur_src <= src_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    src_nxt   = cur_src;
    case (state)
      IDLE: begin
        if (pick_vld) begin
          state_nxt = SHOW;
          src_nxt   = pick_idx;
        end
      end
      SHOW: begin
        // A lone requester at expiry simply restarts its dwell without blanking.
        if (!cur_req || hold_exp) begin
          if (others)        state_nxt = GAP;
          else if (!cur_req) state_nxt = IDLE;
        end
      end
      GAP: begin
        if (gap_exp) begin
          if (pick_vld) begin
            state_nxt = SHOW;
            src_nxt   = pick_idx;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    dat_d   = '0;
    pt_d    = '0;
    blank_d = 1'b1;
    gnt_d   = '0;
    if (state_nxt == SHOW) begin
      dat_d   = src_dat[16*int'(src_nxt) +: 16];
      pt_d    = src_pt[2*int'(src_nxt) +: 2];
      blank_d = 1'b0;
      gnt_d   = N_SRC'(1) << src_nxt;
    end
  end

  // Counters clear on every state change, so a strobe in the entry cycle is never counted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_cnt <= '0;
      gap_cnt  <= '0;
      dat      <= '0;
      pt       <= '0;
      blank    <= 1'b1;
      gnt      <= '0;
    end else begin
      hold_cnt <= (state == SHOW && state_nxt == SHOW && !hold_exp) ? hold_cnt + HW'(ce_1ms) : '0;
      gap_cnt  <= (state == GAP && !gap_exp) ? gap_cnt + BW'(ce_1ms) : '0;
      dat      <= dat_d;
      pt       <= pt_d;
      blank    <= blank_d;
      gnt      <= gnt_d;
    end
  end

endmodule

// File: tb/tb_disp_src_sched.sv
// Directed vector table plus hand sequences and a randomized invariant/fairness phase
// for disp_src_sched with HOLD_MS=3, BLANK_MS=1, N_SRC=4.
module tb_disp_src_sched;

  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ce_1ms;
  logic [N-1:0]  req;
  logic [16*N-1:0] src_dat;
  logic [2*N-1:0]  src_pt;
  logic [15:0]   dat;
  logic [1:0]    pt;
  logic          blank;
  logic [N-1:0]  gnt;
  logic [1:0]    cur_src;

  int total = 0;
  int bad   = 0;

  disp_src_sched #(.N_SRC(N), .HOLD_MS(3), .BLANK_MS(1)) dut (
    .clk(clk), .rst_n(rst_n), .ce_1ms(ce_1ms), .req(req),
    .src_dat(src_dat), .src_pt(src_pt),
    .dat(dat), .pt(pt), .blank(blank), .gnt(gnt), .cur_src(cur_src)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic [3:0] req;
    logic       ce;
    logic       e_blank;
    logic [3:0] e_gnt;
    logic [1:0] e_cur;
    logic [15:0] e_dat;
    logic [1:0] e_pt;
  } vec_t;

  vec_t tv[$];

  task automatic add(input logic r, input logic [3:0] q, input logic c,
                     input logic b, input logic [3:0] g, input logic [1:0] cs,
                     input logic [15:0] d, input logic [1:0] p);
    vec_t v;
    v.rst_n = r; v.req = q; v.ce = c; v.e_blank = b; v.e_gnt = g;
    v.e_cur = cs; v.e_dat = d; v.e_pt = p;
    tv.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int since0;
  logic [3:0] rnd;

  initial begin
    rst_n = 1'b0; ce_1ms = 1'b0; req = '0;
    src_dat = {16'h0F0F, 16'hABCD, 16'h5555, 16'h1234};
    src_pt  = {2'd3, 2'd2, 2'd1, 2'd0};

    //   rst req      ce  blank gnt      cur  dat       pt
    add(0, 4'b1111, 0, 1, 4'b0000, 3, 16'h0000, 0);
    add(0, 4'b1111, 1, 1, 4'b0000, 3, 16'h0000, 0);
    add(0, 4'b1111, 0, 1, 4'b0000, 3, 16'h0000, 0);
    add(1, 4'b1111, 1, 0, 4'b0001, 0, 16'h1234, 0);
    add(1, 4'b0101, 1, 0, 4'b0001, 0, 16'h1234, 0);
    add(1, 4'b0101, 0, 0, 4'b0001, 0, 16'h1234, 0);
    add(1, 4'b0101, 1, 0, 4'b0001, 0, 16'h1234, 0);
    add(1, 4'b0101, 1, 1, 4'b0000, 0, 16'h0000, 0);
    add(1, 4'b0101, 0, 1, 4'b0000, 0, 16'h0000, 0);
    add(1, 4'b0101, 1, 0, 4'b0100, 2, 16'hABCD, 2);
    add(1, 4'b0101, 1, 0, 4'b0100, 2, 16'hABCD, 2);
    add(1, 4'b0101, 1, 0, 4'b0100, 2, 16'hABCD, 2);
    add(1, 4'b0101, 1, 1, 4'b0000, 2, 16'h0000, 0);
    add(1, 4'b0101, 1, 0, 4'b0001, 0, 16'h1234, 0);
    add(1, 4'b0001, 1, 0, 4'b0001, 0, 16'h1234, 0);
    add(1, 4'b1000, 0, 1, 4'b0000, 0, 16'h0000, 0);
    add(1, 4'b1000, 1, 0, 4'b1000, 3, 16'h0F0F, 3);
    add(1, 4'b1000, 1, 0, 4'b1000, 3, 16'h0F0F, 3);
    add(1, 4'b1000, 1, 0, 4'b1000, 3, 16'h0F0F, 3);
    add(1, 4'b1000, 1, 0, 4'b1000, 3, 16'h0F0F, 3);
    add(1, 4'b1000, 1, 0, 4'b1000, 3, 16'h0F0F, 3);
    add(1, 4'b1000, 1, 0, 4'b1000, 3, 16'h0F0F, 3);
    add(1, 4'b1001, 1, 1, 4'b0000, 3, 16'h0000, 0);
    add(1, 4'b1001, 1, 0, 4'b0001, 0, 16'h1234, 0);
    add(1, 4'b0000, 0, 1, 4'b0000, 0, 16'h0000, 0);
    add(1, 4'b0000, 1, 1, 4'b0000, 0, 16'h0000, 0);
    add(1, 4'b0010, 0, 0, 4'b0010, 1, 16'h5555, 1);
    add(1, 4'b0011, 1, 0, 4'b0010, 1, 16'h5555, 1);
    add(1, 4'b0011, 1, 0, 4'b0010, 1, 16'h5555, 1);
    add(1, 4'b0011, 1, 1, 4'b0000, 1, 16'h0000, 0);
    add(1, 4'b0000, 1, 1, 4'b0000, 1, 16'h0000, 0);

    #2;
    foreach (tv[i]) begin
      rst_n = tv[i].rst_n; req = tv[i].req; ce_1ms = tv[i].ce;
      step();
      check($sformatf("v%0d.blank", i), 32'(blank),   32'(tv[i].e_blank));
      check($sformatf("v%0d.gnt", i),   32'(gnt),     32'(tv[i].e_gnt));
      check($sformatf("v%0d.cur", i),   32'(cur_src), 32'(tv[i].e_cur));
      check($sformatf("v%0d.dat", i),   32'(dat),     32'(tv[i].e_dat));
      check($sformatf("v%0d.pt", i),    32'(pt),      32'(tv[i].e_pt));
    end

    // Single requester: never blanks across many expiries, and dat follows the source.
    src_dat[31:16] = 16'h0001;
    req = 4'b0010; ce_1ms = 1'b0;
    step();
    check("single.first_gnt", 32'(gnt), 32'h2);
    check("single.first_dat", 32'(dat), 32'h0001);
    for (int c = 0; c < 40; c++) begin
      ce_1ms = (c % 4 == 3);
      step();
      check("single.blank", 32'(blank), 32'h0);
      check("single.gnt",   32'(gnt),   32'h2);
    end
    ce_1ms = 1'b0;
    src_dat[31:16] = 16'h0002;
    step();
    check("single.dat_track", 32'(dat), 32'h0002);
    src_dat[31:16] = 16'h5555;

    // Random phase: req[0] held high must be served within bounded strobes.
    since0 = 0;
    for (int c = 0; c < 4000; c++) begin
      if (c % 8 == 0) begin
        rnd = 4'($urandom);
        req = {rnd[3:1], 1'b1};
      end
      ce_1ms = ($urandom_range(0, 3) == 0);
      step();
      if (ce_1ms) since0++;
      if (gnt[0]) since0 = 0;
      check("inv.onehot", 32'($onehot0(gnt)), 32'h1);
      check("inv.blank_gnt", 32'(blank), 32'(gnt == '0));
      check("fair.src0", 32'(since0 <= N * (3 + 1 + 2)), 32'h1);
    end

    // Reset in the middle of activity aborts immediately.
    rst_n = 1'b0; req = 4'b1111; ce_1ms = 1'b1;
    step();
    check("rst.blank", 32'(blank),   32'h1);
    check("rst.gnt",   32'(gnt),     32'h0);
    check("rst.dat",   32'(dat),     32'h0);
    check("rst.cur",   32'(cur_src), 32'h3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
